// File: rtl/simmem_pkg.sv
// simmem_pkg: shared write-address/response payload types for the simulated memory.
package simmem_pkg;
  localparam int NumWriteRequesters = 4;
  localparam int IDWidth = 6;
  localparam int AddrWidth = 32;
  typedef struct packed {
    logic [IDWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
  } waddr_req_t;
  typedef struct packed {
    logic [IDWidth-1:0] id;
    logic [1:0]         resp;
  } wresp_t;
endpackage

// File: rtl/simmem_waddr_arbiter_if.sv
// simmem_waddr_arbiter_if: requester, write-address and write-response channels of the arbiter.
interface simmem_waddr_arbiter_if import simmem_pkg::*; #(parameter int NumReq = NumWriteRequesters) ();
  logic [NumReq-1:0] req_valid_i;
  logic [NumReq-1:0] req_ready_o;
  waddr_req_t        req_data_i [NumReq];
  logic              waddr_valid_o;
  logic              waddr_ready_i;
  waddr_req_t        waddr_data_o;
  logic              wresp_valid_i;
  logic              wresp_ready_o;
  wresp_t            wresp_data_i;
  logic [NumReq-1:0] rsp_valid_o;
  logic [NumReq-1:0] rsp_ready_i;
  wresp_t            rsp_data_o;
  logic              err_o;
  modport slave (
    input  req_valid_i, req_data_i, waddr_ready_i, wresp_valid_i, wresp_data_i, rsp_ready_i,
    output req_ready_o, waddr_valid_o, waddr_data_o, wresp_ready_o, rsp_valid_o, rsp_data_o, err_o
  );
  modport master (
    output req_valid_i, req_data_i, waddr_ready_i, wresp_valid_i, wresp_data_i, rsp_ready_i,
    input  req_ready_o, waddr_valid_o, waddr_data_o, wresp_ready_o, rsp_valid_o, rsp_data_o, err_o
  );
endinterface

// File: rtl/simmem_rr_arbiter.sv
// simmem_rr_arbiter: first set request bit at or after ptr_i, wrapping modulo NumReq.
module simmem_rr_arbiter #(
  parameter int NumReq = 4
) (
  input  logic [NumReq-1:0]         req_i,
  input  logic [$clog2(NumReq)-1:0] ptr_i,
  output logic [$clog2(NumReq)-1:0] gnt_o,
  output logic                      valid_o
);
  localparam int LW = $clog2(NumReq);
  // Scan farthest offset first so the nearest one after the pointer wins.
  always_comb begin
    gnt_o = ptr_i;
    valid_o = 1'b0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (req_i[ptr_i + LW'(i)]) begin
        gnt_o = ptr_i + LW'(i);
        valid_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/simmem_waddr_arbiter.sv
// simmem_waddr_arbiter: round-robin write-address arbiter with per-requester outstanding
// limits and ID-based write-response routing.
module simmem_waddr_arbiter import simmem_pkg::*; #(
  parameter int NumReq = 4,
  parameter int MaxOutstanding = 8
) (
  input logic                   clk_i,
  input logic                   rst_i,
  simmem_waddr_arbiter_if.slave bus
);
  localparam int LW = $clog2(NumReq);
  localparam int CW = $clog2(MaxOutstanding + 1);
  logic [CW-1:0]     cnt_q [NumReq];
  logic [CW-1:0]     cnt_d [NumReq];
  logic [LW-1:0]     rr_ptr_q, rr_ptr_d, lock_gnt_q, lock_gnt_d, arb_idx, gnt, rsp_idx;
  logic              lock_q, lock_d, err_q, err_d, arb_v, gnt_v, aw_hs, b_hs;
  logic [NumReq-1:0] elig;
  always_comb begin
    for (int k = 0; k < NumReq; k++) elig[k] = bus.req_valid_i[k] && (cnt_q[k] < CW'(MaxOutstanding));
  end
  simmem_rr_arbiter #(.NumReq(NumReq)) u_rr (
    .req_i(elig), .ptr_i(rr_ptr_q), .gnt_o(arb_idx), .valid_o(arb_v)
  );
  // A stalled grant is frozen until its handshake, ignoring eligibility changes.
  always_comb begin
    gnt = lock_q ? lock_gnt_q : arb_idx;
    gnt_v = lock_q | arb_v;
    aw_hs = gnt_v & bus.waddr_ready_i;
    rsp_idx = bus.wresp_data_i.id[IDWidth-1 -: LW];
    b_hs = bus.wresp_valid_i & bus.rsp_ready_i[rsp_idx];
    bus.waddr_valid_o = gnt_v;
    bus.waddr_data_o = bus.req_data_i[gnt];
    bus.req_ready_o = NumReq'(aw_hs) << gnt;
    bus.rsp_valid_o = NumReq'(bus.wresp_valid_i) << rsp_idx;
    bus.wresp_ready_o = bus.rsp_ready_i[rsp_idx];
    bus.rsp_data_o = bus.wresp_data_i;
    bus.err_o = err_q;
    lock_d = gnt_v & ~bus.waddr_ready_i;
    lock_gnt_d = gnt;
    rr_ptr_d = aw_hs ? gnt + LW'(1) : rr_ptr_q;
    err_d = err_q | (b_hs && cnt_q[rsp_idx] == '0);
    for (int k = 0; k < NumReq; k++)
      cnt_d[k] = cnt_q[k] + CW'(aw_hs && gnt == LW'(k)) - CW'(b_hs && rsp_idx == LW'(k) && cnt_q[k] != '0);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NumReq; k++) cnt_q[k] <= '0;
      rr_ptr_q <= '0;
      lock_gnt_q <= '0;
      lock_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      for (int k = 0; k < NumReq; k++) cnt_q[k] <= cnt_d[k];
      rr_ptr_q <= rr_ptr_d;
      lock_gnt_q <= lock_gnt_d;
      lock_q <= lock_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_simmem_waddr_arbiter.sv
// tb_simmem_waddr_arbiter: directed scenarios plus randomized traffic checked every cycle
// against a behavioural model of the arbitration and outstanding-count rules.
module tb_simmem_waddr_arbiter;
  import simmem_pkg::*;
  localparam int MAXO = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int outst [4];
  int ptr;
  bit locked;
  int lgnt;
  bit merr;
  waddr_req_t d2, d3;
  simmem_waddr_arbiter_if #(.NumReq(4)) bus ();
  simmem_waddr_arbiter #(.NumReq(4), .MaxOutstanding(MAXO)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  function automatic int exp_gnt();
    if (locked) return lgnt;
    for (int i = 0; i < 4; i++) begin
      int j;
      j = (ptr + i) % 4;
      if (bus.req_valid_i[j] && outst[j] < MAXO) return j;
    end
    return -1;
  endfunction
  function automatic int ridx();
    return int'(bus.wresp_data_i.id[5:4]);
  endfunction
  function automatic bit bhs();
    return bus.wresp_valid_i && bus.rsp_ready_i[ridx()];
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) outst[k] <= 0;
      ptr <= 0;
      locked <= 1'b0;
      lgnt <= 0;
      merr <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++)
        outst[k] <= outst[k] + ((exp_gnt() == k && bus.waddr_ready_i) ? 1 : 0)
                    - ((bhs() && ridx() == k && outst[k] > 0) ? 1 : 0);
      merr <= merr | (bhs() && outst[ridx()] == 0);
      locked <= exp_gnt() >= 0 && !bus.waddr_ready_i;
      lgnt <= exp_gnt();
      if (exp_gnt() >= 0 && bus.waddr_ready_i) ptr <= (exp_gnt() + 1) % 4;
    end
  end
  always @(negedge clk) begin
    chk("waddr_valid", 64'(bus.waddr_valid_o), 64'(exp_gnt() >= 0));
    if (exp_gnt() >= 0) chk("waddr_data", 64'(bus.waddr_data_o), 64'(bus.req_data_i[exp_gnt()]));
    chk("req_ready", 64'(bus.req_ready_o), (exp_gnt() >= 0 && bus.waddr_ready_i) ? 64'(1) << exp_gnt() : 64'(0));
    chk("rsp_valid", 64'(bus.rsp_valid_o), bus.wresp_valid_i ? 64'(1) << ridx() : 64'(0));
    chk("wresp_ready", 64'(bus.wresp_ready_o), 64'(bus.rsp_ready_i[ridx()]));
    chk("rsp_data", 64'(bus.rsp_data_o), 64'(bus.wresp_data_i));
    chk("err", 64'(bus.err_o), 64'(merr));
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.req_valid_i = '0;
    bus.waddr_ready_i = 1'b0;
    bus.wresp_valid_i = 1'b0;
    bus.wresp_data_i = '0;
    bus.rsp_ready_i = '0;
  endtask
  task automatic set_data();
    for (int k = 0; k < 4; k++)
      bus.req_data_i[k] = '{id: {2'(k), 4'($urandom)}, addr: $urandom, len: 8'($urandom)};
  endtask
  task automatic resp(input int k);
    bus.wresp_valid_i = 1'b1;
    bus.wresp_data_i = '{id: {2'(k), 4'($urandom)}, resp: 2'($urandom)};
    bus.rsp_ready_i = 4'hF;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
  endtask
  initial begin
    idle();
    set_data();
    step();
    do_reset();
    #1;
    chk("reset_wvalid", 64'(bus.waddr_valid_o), 64'd0);
    chk("reset_err", 64'(bus.err_o), 64'd0);
    // round robin between requesters 1 and 3
    bus.req_valid_i = 4'b1010;
    bus.waddr_ready_i = 1'b1;
    #1 chk("rr_first", 64'(bus.req_ready_o), 64'b0010);
    step();
    #1 chk("rr_second", 64'(bus.req_ready_o), 64'b1000);
    step();
    #1 chk("rr_third", 64'(bus.req_ready_o), 64'b0010);
    step();
    // lock on requester 2 while requester 0 competes
    do_reset();
    d2 = bus.req_data_i[2];
    bus.req_valid_i = 4'b0100;
    #1 chk("lock_ready0", 64'(bus.req_ready_o), 64'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      bus.req_valid_i = 4'b0101;
      #1;
      chk("lock_valid", 64'(bus.waddr_valid_o), 64'd1);
      chk("lock_data", 64'(bus.waddr_data_o), 64'(d2));
      chk("lock_ready", 64'(bus.req_ready_o), 64'd0);
    end
    bus.waddr_ready_i = 1'b1;
    #1 chk("lock_release", 64'(bus.req_ready_o), 64'b0100);
    step();
    // outstanding limit of two on requester 0
    do_reset();
    bus.req_valid_i = 4'b0001;
    bus.waddr_ready_i = 1'b1;
    #1 chk("max_g1", 64'(bus.req_ready_o), 64'b0001);
    step();
    #1 chk("max_g2", 64'(bus.req_ready_o), 64'b0001);
    step();
    #1 chk("max_mask", 64'(bus.waddr_valid_o), 64'd0);
    resp(0);
    #1 chk("max_rsp", 64'(bus.rsp_valid_o), 64'b0001);
    step();
    bus.wresp_valid_i = 1'b0;
    #1 chk("max_regrant", 64'(bus.req_ready_o), 64'b0001);
    step();
    // simultaneous issue and response on requester 1
    do_reset();
    bus.req_valid_i = 4'b0010;
    bus.waddr_ready_i = 1'b1;
    step();
    resp(1);
    #1;
    chk("simul_aw", 64'(bus.req_ready_o), 64'b0010);
    chk("simul_b", 64'(bus.rsp_valid_o), 64'b0010);
    step();
    bus.wresp_valid_i = 1'b0;
    #1 chk("simul_next", 64'(bus.req_ready_o), 64'b0010);
    step();
    #1 chk("simul_mask", 64'(bus.waddr_valid_o), 64'd0);
    // response with nothing outstanding
    do_reset();
    resp(2);
    #1 chk("err_before", 64'(bus.err_o), 64'd0);
    step();
    bus.wresp_valid_i = 1'b0;
    bus.req_valid_i = 4'b0100;
    bus.waddr_ready_i = 1'b1;
    #1;
    chk("err_set", 64'(bus.err_o), 64'd1);
    chk("err_cnt0_a", 64'(bus.req_ready_o), 64'b0100);
    step();
    #1 chk("err_cnt0_b", 64'(bus.req_ready_o), 64'b0100);
    step();
    #1 chk("err_cnt_full", 64'(bus.waddr_valid_o), 64'd0);
    bus.req_valid_i = '0;
    repeat (3) step();
    chk("err_sticky", 64'(bus.err_o), 64'd1);
    // reset while locked on 3 with counts {1,2,0,1} and err set
    do_reset();
    resp(2);
    bus.req_valid_i = 4'b0001;
    bus.waddr_ready_i = 1'b1;
    step();
    bus.wresp_valid_i = 1'b0;
    bus.req_valid_i = 4'b0010;
    step();
    step();
    bus.req_valid_i = 4'b1000;
    step();
    d3 = bus.req_data_i[3];
    bus.waddr_ready_i = 1'b0;
    step();
    rst = 1'b1;
    bus.req_valid_i = 4'b0001;
    #1;
    chk("rst_hold_data", 64'(bus.waddr_data_o), 64'(d3));
    chk("rst_hold_err", 64'(bus.err_o), 64'd1);
    step();
    rst = 1'b0;
    #1;
    chk("rst_err", 64'(bus.err_o), 64'd0);
    chk("rst_unlock", 64'(bus.waddr_data_o.id[5:4]), 64'd0);
    bus.waddr_ready_i = 1'b1;
    #1 chk("rst_g0", 64'(bus.req_ready_o), 64'b0001);
    step();
    bus.req_valid_i = 4'b0010;
    #1 chk("rst_g1a", 64'(bus.req_ready_o), 64'b0010);
    step();
    #1 chk("rst_g1b", 64'(bus.req_ready_o), 64'b0010);
    step();
    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int k;
      rst = ($urandom % 256) == 0;
      set_data();
      bus.req_valid_i = 4'($urandom);
      bus.waddr_ready_i = ($urandom % 4) != 0;
      k = $urandom_range(3);
      if (outst[k] > 0 && $urandom % 2 == 1) resp(k);
      else begin
        bus.wresp_valid_i = 1'b0;
        bus.wresp_data_i = '{id: {2'(k), 4'($urandom)}, resp: 2'($urandom)};
      end
      bus.rsp_ready_i = 4'($urandom);
      step();
    end
    rst = 1'b0;
    idle();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
